// File: rtl/bf_pkg.sv
// Shared opcodes, FSM state codes and default widths
// for the Brainfuck interpreter core.
package bf_pkg;

    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH_W = 9;

    localparam logic [7:0] OP_INC        = 8'h2B;
    localparam logic [7:0] OP_DEC        = 8'h2D;
    localparam logic [7:0] OP_RIGHT      = 8'h3E;
    localparam logic [7:0] OP_LEFT       = 8'h3C;
    localparam logic [7:0] OP_OUT        = 8'h2E;
    localparam logic [7:0] OP_IN         = 8'h2C;
    localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;
    localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;
    localparam logic [7:0] OP_NUL        = 8'h00;

    // Encodings double as the debug probe value.
    typedef enum logic [3:0] {
        ST_LOAD         = 4'd1,
        ST_FETCH        = 4'd2,
        ST_EXEC         = 4'd3,
        ST_WAIT         = 4'd4,
        ST_IN_WAIT      = 4'd5,
        ST_SCAN_F_FETCH = 4'd6,
        ST_SCAN_F       = 4'd7,
        ST_SCAN_B_FETCH = 4'd8,
        ST_SCAN_B       = 4'd9,
        ST_HALT         = 4'd10
    } state_t;

endpackage

// File: rtl/bf_interp_core_if.sv
// Bus bundle: code ROM, tape RAM and byte I/O.
// master = interpreter core, slave = memories / serial block.
interface bf_interp_core_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] code_out;
    logic [ADDR_W-1:0] addr_code;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] addr_array;
    logic [DATA_W-1:0] dataOut_array;
    logic              write_rq;
    logic              receivingChar;
    logic [DATA_W-1:0] receivedChar;
    logic              sendingChar;
    logic [DATA_W-1:0] sendedChar;

    modport master (
        input  code_out, data_in,
        input  receivingChar, receivedChar,
        output addr_code, addr_array,
        output dataOut_array, write_rq,
        output sendingChar, sendedChar
    );

    modport slave (
        output code_out, data_in,
        output receivingChar, receivedChar,
        input  addr_code, addr_array,
        input  dataOut_array, write_rq,
        input  sendingChar, sendedChar
    );
endinterface

// File: rtl/bf_interp_core.sv
// Brainfuck execution engine: ROM fetch, tape RAM, byte I/O.
// Define BF_HALT_ON_NUL_EN to make opcode 0x00 halt the core.
module bf_interp_core
    import bf_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH_W = DEF_DEPTH_W
) (
    input  logic             clk,
    input  logic             reset,
    bf_interp_core_if.master bus,
    output logic [3:0]       probe
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   cell_q, cell_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [DEPTH_W-1:0]  depth_nx;
    logic [DATA_W-1:0]   snd_q, snd_d;
    logic [DATA_W-1:0]   op;
    logic                send;

    assign op             = bus.code_out;
    assign bus.addr_code  = pc_q;
    assign bus.addr_array = ptr_q;
    assign probe          = 4'(state_q);

    // The output byte is live during the pulse and held afterwards.
    assign bus.sendingChar = send;
    assign bus.sendedChar  = send ? cell_q : snd_q;

    // Architectural state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
            pc_q    <= '0;
            ptr_q   <= '0;
            cell_q  <= '0;
            depth_q <= '0;
            snd_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cell_q  <= cell_d;
            depth_q <= depth_d;
            snd_q   <= snd_d;
        end
    end

    // Next-state decode and single-cycle strobes.
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        ptr_d             = ptr_q;
        cell_d            = cell_q;
        depth_d           = depth_q;
        snd_d             = snd_q;
        depth_nx          = depth_q;
        send              = 1'b0;
        bus.write_rq      = 1'b0;
        bus.dataOut_array = '0;
        case (state_q)
            ST_WAIT:  state_d = ST_LOAD;
            ST_LOAD: begin
                cell_d  = bus.data_in;
                state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                pc_d    = pc_q + 1'b1;
                state_d = ST_FETCH;
                case (op)
                    OP_INC, OP_DEC: begin
                        cell_d = (op == OP_INC) ? cell_q + 1'b1
                                                : cell_q - 1'b1;
                        bus.write_rq      = 1'b1;
                        bus.dataOut_array = cell_d;
                    end
                    OP_RIGHT: begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_WAIT;
                    end
                    OP_LEFT: begin
                        ptr_d   = ptr_q - 1'b1;
                        state_d = ST_WAIT;
                    end
                    OP_OUT: begin
                        send  = 1'b1;
                        snd_d = cell_q;
                    end
                    OP_IN: begin
                        pc_d    = pc_q;
                        state_d = ST_IN_WAIT;
                    end
                    OP_LOOP_OPEN: begin
                        if (cell_q == '0) begin
                            depth_d = DEPTH_W'(1);
                            state_d = ST_SCAN_F_FETCH;
                        end
                    end
                    OP_LOOP_CLOSE: begin
                        if (cell_q != '0) begin
                            depth_d = DEPTH_W'(1);
                            pc_d    = pc_q - 1'b1;
                            state_d = ST_SCAN_B_FETCH;
                        end
                    end
`ifdef BF_HALT_ON_NUL_EN
                    OP_NUL: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
`endif
                    default: ;
                endcase
            end
            ST_IN_WAIT: begin
                if (bus.receivingChar) begin
                    cell_d            = bus.receivedChar;
                    bus.write_rq      = 1'b1;
                    bus.dataOut_array = bus.receivedChar;
                    pc_d              = pc_q + 1'b1;
                    state_d           = ST_FETCH;
                end
            end
            ST_SCAN_F_FETCH: state_d = ST_SCAN_F;
            ST_SCAN_F: begin
                if (op == OP_LOOP_OPEN)
                    depth_nx = depth_q + 1'b1;
                else if (op == OP_LOOP_CLOSE)
                    depth_nx = depth_q - 1'b1;
                depth_d = depth_nx;
                pc_d    = pc_q + 1'b1;
                state_d = (depth_nx == '0) ? ST_FETCH
                                           : ST_SCAN_F_FETCH;
`ifdef BF_HALT_ON_NUL_EN
                if (op == OP_NUL) begin
                    depth_d = depth_q;
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
`endif
            end
            ST_SCAN_B_FETCH: state_d = ST_SCAN_B;
            ST_SCAN_B: begin
                if (op == OP_LOOP_CLOSE)
                    depth_nx = depth_q + 1'b1;
                else if (op == OP_LOOP_OPEN)
                    depth_nx = depth_q - 1'b1;
                depth_d = depth_nx;
                if (depth_nx == '0) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    pc_d    = pc_q - 1'b1;
                    state_d = ST_SCAN_B_FETCH;
                end
`ifdef BF_HALT_ON_NUL_EN
                if (op == OP_NUL) begin
                    depth_d = depth_q;
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
`endif
            end
            ST_HALT: ;
            default: state_d = ST_WAIT;
        endcase
    end

endmodule

// File: tb/tb_bf_interp_core.sv
// Directed bench for bf_interp_core with behavioural
// synchronous ROM and tape RAM models.
module tb_bf_interp_core;
    import bf_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_clr;
    logic [3:0] probe;
    logic [7:0] rom [512];
    logic [7:0] mem [512];

    logic [8:0] wa [$];
    logic [7:0] wd [$];
    logic [7:0] sends [$];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bf_interp_core_if #(.ADDR_W(9), .DATA_W(8)) bus ();

    bf_interp_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .probe (probe)
    );

    // Synchronous ROM and single-port tape RAM.
    always @(posedge clk) begin
        bus.code_out <= rom[bus.addr_code];
        bus.data_in  <= mem[bus.addr_array];
        if (mem_clr) begin
            for (int i = 0; i < 512; i++)
                mem[i] <= 8'h00;
        end else if (bus.write_rq) begin
            mem[bus.addr_array] <= bus.dataOut_array;
        end
    end

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Sample strobes mid-cycle, then advance one edge.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            if (bus.write_rq) begin
                wa.push_back(bus.addr_array);
                wd.push_back(bus.dataOut_array);
            end
            if (bus.sendingChar)
                sends.push_back(bus.sendedChar);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(string tag, string p);
        for (int i = 0; i < 512; i++)
            rom[i] = 8'h20;
        for (int i = 0; i < p.len(); i++)
            rom[i] = p[i];
        wa.delete();
        wd.delete();
        sends.delete();
        reset   = 1'b1;
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
        tick();
        chk({tag, " rst probe"}, 32'(probe), 32'd4);
        chk({tag, " rst pc"}, 32'(bus.addr_code), 32'd0);
        chk({tag, " rst ptr"}, 32'(bus.addr_array), 32'd0);
        chk({tag, " rst outs"},
            32'({bus.write_rq, bus.sendingChar,
                 bus.sendedChar, bus.dataOut_array}),
            32'd0);
        reset = 1'b0;
    endtask

    task automatic run_to_send(string tag, int budget);
        int c = 0;
        while (sends.size() == 0 && c < budget) begin
            tick();
            c++;
        end
        chk({tag, " send seen"}, 32'(sends.size() > 0), 32'd1);
    endtask

    task automatic wait_probe(string tag, logic [3:0] p);
        int c = 0;
        while (probe != p && c < 40) begin
            tick();
            c++;
        end
        chk({tag, " reach state"}, 32'(probe), 32'(p));
    endtask

    initial begin
        int bad;
        reset         = 1'b1;
        mem_clr       = 1'b0;
        bus.receivingChar = 1'b0;
        bus.receivedChar  = 8'h00;
        for (int i = 0; i < 512; i++)
            mem[i] = 8'h00;

        // "+++." then NUL
        load("t1", "+++.");
        rom[4] = 8'h00;
        run_to_send("t1", 200);
        repeat (6) tick();
        chk("t1 char", 32'(sends[0]), 32'h03);
        chk("t1 nwr", 32'(wa.size()), 32'd3);
        chk("t1 wr0", 32'({wa[0], wd[0]}), 32'({9'd0, 8'h01}));
        chk("t1 wr1", 32'({wa[1], wd[1]}), 32'({9'd0, 8'h02}));
        chk("t1 wr2", 32'({wa[2], wd[2]}), 32'({9'd0, 8'h03}));
        chk("t1 nsend", 32'(sends.size()), 32'd1);
`ifdef BF_HALT_ON_NUL_EN
        chk("t1 halt", 32'(probe), 32'd10);
        chk("t1 pc", 32'(bus.addr_code), 32'd4);
        repeat (5) tick();
        chk("t1 pc held", 32'(bus.addr_code), 32'd4);
        chk("t1 halt held", 32'(probe), 32'd10);
`endif

        // "-." cell wrap
        load("t2", "-.");
        run_to_send("t2", 200);
        chk("t2 char", 32'(sends[0]), 32'hFF);
        chk("t2 ram0", 32'(mem[0]), 32'hFF);

        // "++[->+<]>." move loop
        load("t3", "++[->+<]>.");
        run_to_send("t3", 400);
        chk("t3 char", 32'(sends[0]), 32'h02);
        chk("t3 ram0", 32'(mem[0]), 32'h00);
        chk("t3 ram1", 32'(mem[1]), 32'h02);
        chk("t3 nwr", 32'(wa.size()), 32'd6);
        chk("t3 ptr", 32'(bus.addr_array), 32'd1);

        // ",+." input handshake
        load("t4", ",+.");
        wait_probe("t4", 4'd5);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (probe != 4'd5)
                bad++;
        end
        chk("t4 held in_wait", 32'(bad), 32'd0);
        chk("t4 no wr", 32'(wa.size()), 32'd0);
        bus.receivedChar  = 8'h41;
        bus.receivingChar = 1'b1;
        tick();
        bus.receivingChar = 1'b0;
        bus.receivedChar  = 8'h00;
        chk("t4 in wr", 32'(wd[0]), 32'h41);
        run_to_send("t4", 200);
        chk("t4 char", 32'(sends[0]), 32'h42);
        chk("t4 ram0", 32'(mem[0]), 32'h42);

        // "<+." pointer wrap
        load("t5", "<+.");
        run_to_send("t5", 200);
        chk("t5 wr addr", 32'(wa[0]), 32'h1FF);
        chk("t5 wr data", 32'(wd[0]), 32'h01);
        chk("t5 char", 32'(sends[0]), 32'h01);
        chk("t5 ram", 32'(mem[511]), 32'h01);

        // "[[+]+]." nested forward skip
        load("t6", "[[+]+].");
        run_to_send("t6", 200);
        chk("t6 char", 32'(sends[0]), 32'h00);
        chk("t6 no wr", 32'(wa.size()), 32'd0);

        // reset while waiting for input
        load("t7", ",");
        wait_probe("t7", 4'd5);
        reset = 1'b1;
        tick();
        chk("t7 rst probe", 32'(probe), 32'd4);
        chk("t7 rst pc", 32'(bus.addr_code), 32'd0);

        // reset mid forward scan (unmatched '[')
        load("t8", "[");
        repeat (12) tick();
        chk("t8 scanning",
            32'(probe == 4'd6 || probe == 4'd7), 32'd1);
        reset = 1'b1;
        tick();
        chk("t8 rst probe", 32'(probe), 32'd4);
        chk("t8 rst pc", 32'(bus.addr_code), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bf_interp_core.md
Name: bf_interp_core

Overview:
- Brainfuck execution engine.
- Fetches 8-bit ASCII opcodes from a synchronous code ROM and operates on a tape in a synchronous single-write/single-read data RAM.
- Exchanges characters with a UART-style byte interface.
- Sits between the program ROM, the tape RAM and the serial I/O block; the 4-bit probe exposes FSM state for debug LEDs.

Parameters:
- ADDR_W, 9, width of code address (pc) and tape pointer (ptr); both wrap mod 2^ADDR_W.
- DATA_W, 8, cell and opcode width; cell arithmetic is mod 2^DATA_W.
- DEPTH_W, 9, bracket-nesting counter width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- code_out  in  8  opcode from ROM, valid one cycle after addr_code is presented.
- addr_code  out  ADDR_W  code address; equals pc.
- data_in  in  8  RAM read data, valid one cycle after addr_array is stable.
- addr_array  out  ADDR_W  tape address; equals ptr, used for both read and write.
- dataOut_array  out  8  RAM write data.
- write_rq  out  1  RAM write strobe, single cycle.
- receivingChar  in  1  high when receivedChar holds a valid input byte.
- receivedChar  in  8  input byte.
- sendingChar  out  1  one-cycle pulse: sendedChar is valid.
- sendedChar  out  8  output byte.
- probe  out  4  current state code.

Behaviour:
- Reset:
  - pc=0, ptr=0, cell=0, depth=0, state=WAIT.
  - write_rq=0, sendingChar=0, sendedChar=0, dataOut_array=0.
  - RAM contents are not cleared by the core.
- States (probe code):
  - WAIT(4): one cycle for RAM address to settle -> LOAD.
  - LOAD(1): cell<=data_in -> FETCH.
  - FETCH(2): ROM reads at pc -> EXEC.
  - EXEC(3): decodes code_out as listed below.
- EXEC decode:
  - '+'(0x2B) / '-'(0x2D): cell<=cell±1 with wrap; write_rq=1 and dataOut_array=new value this cycle at the current ptr; pc++ -> FETCH.
  - '>'(0x3E) / '<'(0x3C): ptr±1 with wrap (0 '<' -> 511); pc++ -> WAIT.
  - '.'(0x2E): sendingChar=1 for exactly this cycle, sendedChar<=cell (held until the next '.'); pc++ -> FETCH.
  - ','(0x2C): -> IN_WAIT(5); pc unchanged.
  - '['(0x5B): if cell==0, depth<=1, pc++ -> SCAN_F_FETCH(6); else pc++ -> FETCH.
  - ']'(0x5D): if cell!=0, depth<=1, pc-- -> SCAN_B_FETCH(8); else pc++ -> FETCH.
  - Any other byte is a NOP: pc++ -> FETCH.
- IN_WAIT: holds while receivingChar=0. When receivingChar=1: cell<=receivedChar, write_rq=1, dataOut_array=receivedChar, pc++ -> FETCH.
- SCAN_F_FETCH -> SCAN_F(7):
  - '[' depth++; ']' depth--.
  - If depth reaches 0: pc++ (past the matching ']') -> FETCH.
  - Else: pc++ -> SCAN_F_FETCH.
- SCAN_B_FETCH -> SCAN_B(9):
  - ']' depth++; '[' depth--.
  - If depth reaches 0: pc++ (past the matching '[') -> FETCH.
  - Else: pc-- -> SCAN_B_FETCH.
- HALT(10): all strobes 0; pc/ptr frozen until reset.
- Timing: 2 cycles per simple instruction; pointer moves take 4; each scanned opcode takes 2.
- Unmatched brackets: scanning wraps pc mod 512 and never terminates unless halted.
- Reset asserted in any state, including mid-scan or IN_WAIT, returns to the reset state on the next edge.
- write_rq never coincides with a ptr change.

Optional Feature:
- BF_HALT_ON_NUL_EN defined: opcode 0x00 in EXEC, SCAN_F or SCAN_B -> HALT; pc is not incremented.
- Undefined: 0x00 is a NOP like any other byte, and HALT is unreachable.

Decomposition:
- Package bf_pkg holds:
  - opcode localparams (OP_INC, OP_DEC, OP_RIGHT, OP_LEFT, OP_OUT, OP_IN, OP_LOOP_OPEN, OP_LOOP_CLOSE, OP_NUL);
  - the state enum with the fixed probe codes above;
  - the ADDR_W, DATA_W and DEPTH_W defaults.
- Single module is natural; no sub-module.

Test Plan:
- "+++." then NUL (BF_HALT_ON_NUL_EN) -> one sendingChar pulse with sendedChar=0x03; three write_rq pulses writing 0x01,0x02,0x03 at addr 0; then probe=10 with addr_code held.
- "-." -> sendedChar=0xFF (cell wrap); RAM[0]=0xFF.
- "++[->+<]>." -> sendedChar=0x02; RAM[0]=0x00, RAM[1]=0x02.
- ",+." with receivingChar held 0 for 20 cycles then 1 with receivedChar=0x41 -> probe=5 throughout the wait; then sendedChar=0x42.
- "<+." -> addr_array=0x1FF on the write; sendedChar=0x01.
- "[[+]+]." with cell 0 -> nested forward scan skips to '.'; sendedChar=0x00; no write_rq before the output.
